// File: rtl/timer_tick_gen_pkg.sv
// Shared timer definitions: clk_sel encodings, tick periods and the default select width.
package timer_tick_gen_pkg;

    localparam int DEFAULT_SEL_W = 2;

    typedef enum logic [1:0] {
        CLK_SEL_DIV2  = 2'b00,
        CLK_SEL_DIV4  = 2'b01,
        CLK_SEL_DIV8  = 2'b10,
        CLK_SEL_DIV16 = 2'b11
    } clk_sel_e;

    localparam int PER_CLK_2  = 2;
    localparam int PER_CLK_4  = 4;
    localparam int PER_CLK_8  = 8;
    localparam int PER_CLK_16 = 16;

endpackage

// File: rtl/timer_tick_gen_sync_edge_det.sv
// Two-flop synchronizer plus edge register; o_rise is high for one pclk per rising edge of i_async.
module timer_tick_gen_sync_edge_det (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_rise
);

    logic r_sync1;
    logic r_sync2;
    logic r_sync3;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
        end else begin
            r_sync1 <= i_async;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign o_rise = r_sync2 & ~r_sync3;

endmodule

// File: rtl/timer_tick_gen.sv
// Prescaler feeding the timer counter: one-pclk cnt_tick every 2^(clk_sel+1) counts.
// Optional external count source enabled with macro TIMER_EXT_CLK_EN.
module timer_tick_gen
    import timer_tick_gen_pkg::*;
#(
    parameter int SEL_W = DEFAULT_SEL_W,
    parameter int DIV_W = 4
) (
    input  logic             i_pclk,
    input  logic             i_preset,
    input  logic             i_en,
    input  logic [SEL_W-1:0] i_clk_sel,
    input  logic             i_div_clr,
`ifdef TIMER_EXT_CLK_EN
    input  logic             i_ext_clk,
    input  logic             i_ext_sel,
`endif
    output logic             o_cnt_tick,
    output logic [DIV_W-1:0] o_div_cnt
);

    logic [DIV_W-1:0] r_div_cnt;
    logic             r_cnt_tick;
    logic [SEL_W-1:0] r_sel_q;
    logic             r_en_q;

    logic [SEL_W:0]   w_shamt;
    logic [DIV_W-1:0] w_one;
    logic [DIV_W-1:0] w_tc;
    logic             w_restart;
    logic             w_advance;

    // Shift amount carries an extra bit so clk_sel=11 shifts by 4, not 0.
    assign w_shamt = {1'b0, i_clk_sel} + {{SEL_W{1'b0}}, 1'b1};
    assign w_one   = {{(DIV_W-1){1'b0}}, 1'b1};
    assign w_tc    = (w_one << w_shamt) - w_one;

`ifdef TIMER_EXT_CLK_EN
    logic r_ext_sel_q;
    logic w_base_pulse;

    timer_tick_gen_sync_edge_det u_sync_edge_det (
        .i_clk   (i_pclk),
        .i_rst   (i_preset),
        .i_async (i_ext_clk),
        .o_rise  (w_base_pulse)
    );

    always_ff @(posedge i_pclk) begin
        if (i_preset) begin
            r_ext_sel_q <= 1'b0;
        end else begin
            r_ext_sel_q <= i_ext_sel;
        end
    end

    assign w_restart = (i_en & ~r_en_q)
                     | (i_en & (i_clk_sel != r_sel_q))
                     | (i_en & (i_ext_sel != r_ext_sel_q));
    assign w_advance = ~i_ext_sel | w_base_pulse;
`else
    assign w_restart = (i_en & ~r_en_q) | (i_en & (i_clk_sel != r_sel_q));
    assign w_advance = 1'b1;
`endif

    always_ff @(posedge i_pclk) begin
        if (i_preset) begin
            r_div_cnt  <= '0;
            r_cnt_tick <= 1'b0;
            r_sel_q    <= '0;
            r_en_q     <= 1'b0;
        end else begin
            r_sel_q <= i_clk_sel;
            r_en_q  <= i_en;
            if (i_div_clr || !i_en || w_restart) begin
                r_div_cnt  <= '0;
                r_cnt_tick <= 1'b0;
            end else if (w_advance) begin
                if (r_div_cnt == w_tc) begin
                    r_div_cnt  <= '0;
                    r_cnt_tick <= 1'b1;
                end else begin
                    r_div_cnt  <= r_div_cnt + w_one;
                    r_cnt_tick <= 1'b0;
                end
            end else begin
                r_cnt_tick <= 1'b0;
            end
        end
    end

    assign o_cnt_tick = r_cnt_tick;
    assign o_div_cnt  = r_div_cnt;

endmodule

// File: tb/tb_timer_tick_gen.sv
// Self-checking bench for timer_tick_gen: vector table, long ratio sweeps and optional external source.
module tb_timer_tick_gen;
    import timer_tick_gen_pkg::*;

    typedef struct {
        logic       rst;
        logic       en;
        logic [1:0] sel;
        logic       clr;
        logic       tick;
        logic [3:0] cnt;
    } vec_t;

    typedef struct {
        logic       tick;
        logic [3:0] cnt;
    } exp_t;

    logic       pclk;
    logic       preset;
    logic       en;
    logic [1:0] clk_sel;
    logic       div_clr;
    logic       cnt_tick;
    logic [3:0] div_cnt;
`ifdef TIMER_EXT_CLK_EN
    logic       ext_clk;
    logic       ext_sel;
`endif

    int   total;
    int   bad;
    logic prev_tick;
    vec_t vecs[$];
    exp_t exp_q[$];

    timer_tick_gen #(.SEL_W(2), .DIV_W(4)) dut (
        .i_pclk     (pclk),
        .i_preset   (preset),
        .i_en       (en),
        .i_clk_sel  (clk_sel),
        .i_div_clr  (div_clr),
`ifdef TIMER_EXT_CLK_EN
        .i_ext_clk  (ext_clk),
        .i_ext_sel  (ext_sel),
`endif
        .o_cnt_tick (cnt_tick),
        .o_div_cnt  (div_cnt)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    function automatic void add(input logic rst, input logic e, input logic [1:0] s,
                                input logic c, input logic t, input logic [3:0] n);
        vec_t v;
        v.rst = rst; v.en = e; v.sel = s; v.clr = c; v.tick = t; v.cnt = n;
        vecs.push_back(v);
    endfunction

    task automatic step(input string name, input logic rst, input logic e, input logic [1:0] s,
                        input logic c, input logic t, input logic [3:0] n);
        exp_t x;
        exp_q.push_back('{tick: t, cnt: n});
        preset = rst; en = e; clk_sel = s; div_clr = c;
        @(posedge pclk);
        #1;
        x = exp_q.pop_front();
        total++;
        if (cnt_tick !== x.tick) begin
            bad++;
            $display("FAIL %s tick: got %0b want %0b at %0t", name, cnt_tick, x.tick, $time);
        end
        total++;
        if (div_cnt !== x.cnt) begin
            bad++;
            $display("FAIL %s div_cnt: got %0d want %0d at %0t", name, div_cnt, x.cnt, $time);
        end
        if (cnt_tick === 1'b1) begin
            total++;
            if (prev_tick === 1'b1) begin
                bad++;
                $display("FAIL %s adjacent: got two ticks in a row want isolated at %0t", name, $time);
            end
        end
        prev_tick = cnt_tick;
    endtask

    task automatic run_div(input string name, input logic [1:0] s, input int nticks);
        int n;
        int ticks;
        int peak;
        case (s)
            CLK_SEL_DIV2:  n = PER_CLK_2;
            CLK_SEL_DIV4:  n = PER_CLK_4;
            CLK_SEL_DIV8:  n = PER_CLK_8;
            default:       n = PER_CLK_16;
        endcase
        step({name, "_rst"}, 1'b1, 1'b0, s, 1'b0, 1'b0, 4'd0);
        step({name, "_en"}, 1'b0, 1'b1, s, 1'b0, 1'b0, 4'd0);
        ticks = 0;
        peak  = 0;
        for (int k = 1; k <= nticks * n; k++) begin
            step(name, 1'b0, 1'b1, s, 1'b0, (k % n) == 0, 4'(k % n));
            if (cnt_tick === 1'b1) ticks++;
            if (int'(div_cnt) > peak) peak = int'(div_cnt);
        end
        total++;
        if (ticks != nticks) begin
            bad++;
            $display("FAIL %s tick_count: got %0d want %0d", name, ticks, nticks);
        end
        total++;
        if (peak != n - 1) begin
            bad++;
            $display("FAIL %s peak: got %0d want %0d", name, peak, n - 1);
        end
    endtask

    initial begin
        total = 0; bad = 0; prev_tick = 1'b0;
        preset = 1'b1; en = 1'b0; clk_sel = 2'b00; div_clr = 1'b0;
`ifdef TIMER_EXT_CLK_EN
        ext_clk = 1'b0; ext_sel = 1'b0;
`endif
        @(posedge pclk);
        #1;

        // Reset, idle, enable latency, div_clr at TC, en drop at TC.
        add(1, 0, 2'b01, 0, 0, 0);
        add(0, 0, 2'b01, 0, 0, 0);
        add(0, 0, 2'b01, 0, 0, 0);
        add(0, 1, 2'b01, 0, 0, 0);
        for (int k = 1; k <= 3; k++) add(0, 1, 2'b01, 0, 0, 4'(k));
        add(0, 1, 2'b01, 0, 1, 0);
        for (int k = 1; k <= 3; k++) add(0, 1, 2'b01, 0, 0, 4'(k));
        add(0, 1, 2'b01, 1, 0, 0);
        for (int k = 1; k <= 3; k++) add(0, 1, 2'b01, 0, 0, 4'(k));
        add(0, 1, 2'b01, 0, 1, 0);
        for (int k = 1; k <= 3; k++) add(0, 1, 2'b01, 0, 0, 4'(k));
        add(0, 0, 2'b01, 0, 0, 0);
        add(0, 0, 2'b01, 0, 0, 0);
        add(0, 1, 2'b01, 0, 0, 0);
        add(0, 1, 2'b01, 0, 0, 1);
        // Ratio change /16 -> /2 at div_cnt=9.
        add(0, 1, 2'b11, 0, 0, 0);
        for (int k = 1; k <= 9; k++) add(0, 1, 2'b11, 0, 0, 4'(k));
        add(0, 1, 2'b00, 0, 0, 0);
        add(0, 1, 2'b00, 0, 0, 1);
        add(0, 1, 2'b00, 0, 1, 0);
        add(0, 1, 2'b00, 0, 0, 1);
        add(0, 1, 2'b00, 0, 1, 0);
        // Reset mid-count at div_cnt=5 with en held high.
        add(0, 1, 2'b11, 0, 0, 0);
        for (int k = 1; k <= 5; k++) add(0, 1, 2'b11, 0, 0, 4'(k));
        add(1, 1, 2'b11, 0, 0, 0);
        add(0, 1, 2'b11, 0, 0, 0);
        for (int k = 1; k <= 15; k++) add(0, 1, 2'b11, 0, 0, 4'(k));
        add(0, 1, 2'b11, 0, 1, 0);

        foreach (vecs[i])
            step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].en, vecs[i].sel, vecs[i].clr,
                 vecs[i].tick, vecs[i].cnt);

        run_div("div4", 2'b01, 256);
        run_div("div2", 2'b00, 100);
        run_div("div8", 2'b10, 100);
        run_div("div16", 2'b11, 100);

`ifdef TIMER_EXT_CLK_EN
        begin
            int ext_ticks;
            int gap;
            int last;
            preset = 1'b1; en = 1'b0; clk_sel = 2'b00; ext_sel = 1'b1;
            @(posedge pclk);
            #1;
            preset = 1'b0; en = 1'b1;
            fork
                begin
                    repeat (20) begin
                        #50 ext_clk = 1'b1;
                        #50 ext_clk = 1'b0;
                    end
                end
            join_none
            ext_ticks = 0;
            last = -1;
            for (int c = 0; c < 220; c++) begin
                @(posedge pclk);
                #1;
                if (cnt_tick === 1'b1) begin
                    if (last >= 0) begin
                        gap = c - last;
                        total++;
                        if (gap != 20) begin
                            bad++;
                            $display("FAIL ext_period: got %0d want 20", gap);
                        end
                    end
                    last = c;
                    ext_ticks++;
                end
            end
            total++;
            if (ext_ticks != 10) begin
                bad++;
                $display("FAIL ext_tick_count: got %0d want 10", ext_ticks);
            end
            ext_sel = 1'b0;
        end
`endif

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
